// File: rtl/mm_lsu_pkg.sv
// Shared types for the memory-stage load/store unit: pipeline packets, FSM states,
// exception bit indices and the funct3 access-size decode.
package mm_lsu_pkg;

  localparam int unsigned XLEN_MAX = 64;

  localparam int unsigned MM_EXC_LOAD_MISALIGN  = 0;
  localparam int unsigned MM_EXC_STORE_MISALIGN = 1;
  localparam int unsigned MM_EXC_ILLEGAL_WIDTH  = 2;

  typedef struct packed {
    logic                ena;
    logic                write;
    logic [2:0]          funct3;
    logic [XLEN_MAX-1:0] addr;
    logic [XLEN_MAX-1:0] wdata;
  } mempack_t;

  typedef struct packed {
    logic [4:0]          rd;
    logic                rd_en;
    logic [XLEN_MAX-1:0] res;
  } regpack_t;

  typedef struct packed {
    logic mm_read;
  } decode_sign_t;

  typedef enum logic [1:0] {StIdle, StWait, StDone, StDrain} lsu_state_e;

  typedef struct packed {
    logic [1:0] size_log2;
    logic       is_signed;
  } size_dec_t;

  // B/H/W/D map onto funct3[1:0]; funct3[2] marks the unsigned load variants.
  function automatic size_dec_t decode_size(input logic [2:0] funct3);
    size_dec_t dec;
    dec.size_log2 = funct3[1:0];
    dec.is_signed = ~funct3[2];
    return dec;
  endfunction

endpackage

// File: rtl/mm_lsu_align.sv
// Read-data lane alignment: shifts the addressed bytes down to bit 0, truncates to the
// access size and sign- or zero-extends to XLEN.
module mm_lsu_align #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned OFF  = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [OFF-1:0]  off_i,
  input  logic [1:0]      size_log2_i,
  input  logic            sign_i,
  output logic [XLEN-1:0] result_o
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;
  logic            sign_bit;

  assign shifted = rdata_i >> {off_i, 3'b000};

  always_comb begin
    int bits;
    mask = '0;
    bits = 8 << size_log2_i;
    for (int i = 0; i < int'(XLEN); i++) begin
      mask[i] = (i < bits);
    end
  end

  always_comb begin
    sign_bit = 1'b0;
    unique case (size_log2_i)
      2'd0:    sign_bit = shifted[7];
      2'd1:    sign_bit = shifted[15];
      2'd2:    sign_bit = shifted[31];
      default: sign_bit = shifted[XLEN-1];
    endcase
  end

  assign result_o = (shifted & mask) | ((sign_i && sign_bit) ? ~mask : '0);

endmodule

// File: rtl/mm_lsu.sv
// Memory-stage load/store unit: drives a split address/data bus handshake, stalls the
// pipeline while an access is outstanding and drains responses of flushed accesses.
module mm_lsu
  import mm_lsu_pkg::*;
#(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned ISSUE_NUM = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              mm_valid,
  input  mempack_t                          mm_mempack,
  input  regpack_t     [ISSUE_NUM-1:0]      mm_get,
  input  decode_sign_t [ISSUE_NUM-1:0]      mm_decode_sign,
  input  logic                              flush,
  input  logic                              wb_stall,
  output regpack_t     [ISSUE_NUM-1:0]      mm_put,
  output logic                              mm_stall,
  output logic [2:0]                        mm_exc,
  output logic                              dbus_req,
  output logic                              dbus_we,
  output logic [XLEN-1:0]                   dbus_addr,
  output logic [XLEN/8-1:0]                 dbus_wstrb,
  output logic [XLEN-1:0]                   dbus_wdata,
  output logic [3:0]                        dbus_rlen,
  input  logic                              dbus_addr_ok,
  input  logic                              dbus_data_ok,
  input  logic [XLEN-1:0]                   dbus_rdata
);

  localparam int unsigned OFF = $clog2(XLEN / 8);
  localparam int unsigned NB  = XLEN / 8;

  lsu_state_e      state_q, state_d;
  logic [1:0]      size_q, size_d;
  logic            sign_q, sign_d;
  logic            we_q, we_d;
  logic [OFF-1:0]  off_q, off_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  size_dec_t       dec;
  logic [OFF-1:0]  off;
  logic            live;
  logic            access;
  logic            misaligned;
  logic            ill_width;
  logic [2:0]      exc_raw;
  logic [NB-1:0]   strb_base;
  logic [XLEN-1:0] wdata_rep;
  logic [XLEN-1:0] aligned;
  logic [63:0]     load_res64;

  assign dec    = decode_size(mm_mempack.funct3);
  assign off    = mm_mempack.addr[OFF-1:0];
  assign live   = mm_valid & mm_mempack.ena;
  assign access = live & ~flush;

  always_comb begin
    misaligned = 1'b0;
    unique case (dec.size_log2)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = |off[1:0];
      default: misaligned = |off;
    endcase
  end

  // Doubleword and LWU do not exist on a 32-bit datapath.
  assign ill_width = (XLEN == 32) &&
                     ((mm_mempack.funct3 == 3'b011) ||
                      (!mm_mempack.write && mm_mempack.funct3 == 3'b110));

  always_comb begin
    exc_raw                        = '0;
    exc_raw[MM_EXC_LOAD_MISALIGN]  = misaligned & ~mm_mempack.write;
    exc_raw[MM_EXC_STORE_MISALIGN] = misaligned & mm_mempack.write;
    exc_raw[MM_EXC_ILLEGAL_WIDTH]  = ill_width;
  end

  assign mm_exc = live ? exc_raw : 3'b000;

  always_comb begin
    strb_base = '0;
    unique case (dec.size_log2)
      2'd0:    strb_base = NB'(1);
      2'd1:    strb_base = NB'(3);
      2'd2:    strb_base = NB'(15);
      default: strb_base = '1;
    endcase
  end

  always_comb begin
    wdata_rep = '0;
    unique case (dec.size_log2)
      2'd0:    wdata_rep = {(XLEN / 8){mm_mempack.wdata[7:0]}};
      2'd1:    wdata_rep = {(XLEN / 16){mm_mempack.wdata[15:0]}};
      2'd2:    wdata_rep = {(XLEN / 32){mm_mempack.wdata[31:0]}};
      default: wdata_rep = mm_mempack.wdata[XLEN-1:0];
    endcase
  end

  assign dbus_req   = (state_q == StIdle) & access & ~|exc_raw;
  assign dbus_we    = dbus_req & mm_mempack.write;
  assign dbus_addr  = mm_mempack.addr[XLEN-1:0];
  assign dbus_wstrb = dbus_we ? (strb_base << off) : '0;
  assign dbus_wdata = wdata_rep;
  assign dbus_rlen  = dbus_req ? (4'd1 << dec.size_log2) : 4'd0;

  mm_lsu_align #(
    .XLEN (XLEN),
    .OFF  (OFF)
  ) u_align (
    .rdata_i     (dbus_rdata),
    .off_i       (off_q),
    .size_log2_i (size_q),
    .sign_i      (sign_q),
    .result_o    (aligned)
  );

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    sign_d  = sign_q;
    we_d    = we_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (dbus_req && dbus_addr_ok) begin
          state_d = StWait;
          size_d  = dec.size_log2;
          sign_d  = dec.is_signed;
          we_d    = mm_mempack.write;
          off_d   = off;
        end
      end
      StWait: begin
        if (dbus_data_ok) begin
          state_d = flush ? StIdle : StDone;
          // Only loads update the result register; a killed load keeps the old value.
          if (!flush && !we_q) rdata_d = aligned;
        end else if (flush) begin
          state_d = StDrain;
        end
      end
      StDone: begin
        if (!wb_stall || flush) state_d = StIdle;
      end
      StDrain: begin
        if (dbus_data_ok) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      size_q  <= '0;
      sign_q  <= 1'b0;
      we_q    <= 1'b0;
      off_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      we_q    <= we_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
    end
  end

  assign mm_stall = ((state_q == StIdle) & dbus_req) | (state_q == StWait) |
                    (state_q == StDrain);

  always_comb begin
    load_res64              = '0;
    load_res64[XLEN-1:0]    = rdata_q;
  end

  always_comb begin
    mm_put = mm_get;
    for (int i = 0; i < int'(ISSUE_NUM); i++) begin
      if (mm_decode_sign[i].mm_read) mm_put[i].res = load_res64;
    end
  end

endmodule

// File: tb/tb_mm_lsu.sv
// Directed bench for mm_lsu: a 64-bit instance exercising loads, stores, exceptions,
// flush/drain and writeback stall, plus a 32-bit instance for width-illegal accesses.
module tb_mm_lsu;
  import mm_lsu_pkg::*;

  localparam int unsigned IssueNum = 2;

  logic clk;
  logic rst_n;

  // 64-bit instance
  logic                          mm_valid;
  mempack_t                      mm_mempack;
  regpack_t     [IssueNum-1:0]   mm_get;
  decode_sign_t [IssueNum-1:0]   mm_decode_sign;
  logic                          flush;
  logic                          wb_stall;
  regpack_t     [IssueNum-1:0]   mm_put;
  logic                          mm_stall;
  logic [2:0]                    mm_exc;
  logic                          dbus_req;
  logic                          dbus_we;
  logic [63:0]                   dbus_addr;
  logic [7:0]                    dbus_wstrb;
  logic [63:0]                   dbus_wdata;
  logic [3:0]                    dbus_rlen;
  logic                          dbus_addr_ok;
  logic                          dbus_data_ok;
  logic [63:0]                   dbus_rdata;

  // 32-bit instance
  logic                          v32;
  mempack_t                      mp32;
  regpack_t     [IssueNum-1:0]   put32;
  logic                          stall32;
  logic [2:0]                    exc32;
  logic                          req32;
  logic                          we32;
  logic [31:0]                   addr32;
  logic [3:0]                    wstrb32;
  logic [31:0]                   wdata32;
  logic [3:0]                    rlen32;

  int n_total = 0;
  int n_bad   = 0;

  mm_lsu #(
    .XLEN      (64),
    .ISSUE_NUM (IssueNum)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mm_valid       (mm_valid),
    .mm_mempack     (mm_mempack),
    .mm_get         (mm_get),
    .mm_decode_sign (mm_decode_sign),
    .flush          (flush),
    .wb_stall       (wb_stall),
    .mm_put         (mm_put),
    .mm_stall       (mm_stall),
    .mm_exc         (mm_exc),
    .dbus_req       (dbus_req),
    .dbus_we        (dbus_we),
    .dbus_addr      (dbus_addr),
    .dbus_wstrb     (dbus_wstrb),
    .dbus_wdata     (dbus_wdata),
    .dbus_rlen      (dbus_rlen),
    .dbus_addr_ok   (dbus_addr_ok),
    .dbus_data_ok   (dbus_data_ok),
    .dbus_rdata     (dbus_rdata)
  );

  mm_lsu #(
    .XLEN      (32),
    .ISSUE_NUM (IssueNum)
  ) u_dut32 (
    .clk            (clk),
    .rst_n          (rst_n),
    .mm_valid       (v32),
    .mm_mempack     (mp32),
    .mm_get         (mm_get),
    .mm_decode_sign (mm_decode_sign),
    .flush          (1'b0),
    .wb_stall       (1'b0),
    .mm_put         (put32),
    .mm_stall       (stall32),
    .mm_exc         (exc32),
    .dbus_req       (req32),
    .dbus_we        (we32),
    .dbus_addr      (addr32),
    .dbus_wstrb     (wstrb32),
    .dbus_wdata     (wdata32),
    .dbus_rlen      (rlen32),
    .dbus_addr_ok   (1'b0),
    .dbus_data_ok   (1'b0),
    .dbus_rdata     (32'h0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_op(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wdata);
    mm_mempack.ena    = 1'b1;
    mm_mempack.write  = wr;
    mm_mempack.funct3 = f3;
    mm_mempack.addr   = addr;
    mm_mempack.wdata  = wdata;
    mm_valid          = 1'b1;
  endtask

  // Full load with one-cycle addr_ok, one idle WAIT cycle, then data_ok.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] rdata, input logic [63:0] exp);
    set_op(1'b0, f3, addr, 64'h0);
    dbus_addr_ok = 1'b1;
    #1;
    check({tag, ".req"}, 64'(dbus_req), 64'd1);
    check({tag, ".stall_req"}, 64'(mm_stall), 64'd1);
    check({tag, ".addr"}, dbus_addr, addr);
    @(negedge clk);
    dbus_addr_ok = 1'b0;
    #1;
    check({tag, ".wait_req"}, 64'(dbus_req), 64'd0);
    check({tag, ".stall_wait"}, 64'(mm_stall), 64'd1);
    @(negedge clk);
    dbus_data_ok = 1'b1;
    dbus_rdata   = rdata;
    #1;
    check({tag, ".stall_dataok"}, 64'(mm_stall), 64'd1);
    @(negedge clk);
    dbus_data_ok = 1'b0;
    dbus_rdata   = 64'h0;
    #1;
    check({tag, ".stall_done"}, 64'(mm_stall), 64'd0);
    check({tag, ".res"}, mm_put[0].res, exp);
    mm_valid = 1'b0;
    @(negedge clk);
    #1;
    check({tag, ".idle_stall"}, 64'(mm_stall), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    mm_valid       = 1'b0;
    mm_mempack     = '0;
    flush          = 1'b0;
    wb_stall       = 1'b0;
    dbus_addr_ok   = 1'b0;
    dbus_data_ok   = 1'b0;
    dbus_rdata     = 64'h0;
    v32            = 1'b0;
    mp32           = '0;
    mm_get[0]      = '{rd: 5'd3, rd_en: 1'b1, res: 64'h1111};
    mm_get[1]      = '{rd: 5'd7, rd_en: 1'b1, res: 64'h2222};
    mm_decode_sign[0].mm_read = 1'b1;
    mm_decode_sign[1].mm_read = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst.req", 64'(dbus_req), 64'd0);
    check("rst.we", 64'(dbus_we), 64'd0);
    check("rst.wstrb", 64'(dbus_wstrb), 64'd0);
    check("rst.stall", 64'(mm_stall), 64'd0);
    check("rst.exc", 64'(mm_exc), 64'd0);
    check("rst.res0", mm_put[0].res, 64'h0);
    check("rst.res1", mm_put[1].res, 64'h2222);
    check("rst.rd0", 64'(mm_put[0].rd), 64'd3);
    @(negedge clk);
    rst_n = 1'b1;

    // LB at offset 3: byte 0x80 sign-extends
    do_load("lb", 3'b000, 64'h1003, 64'h00000000_80000000, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb.rlen", 64'(dbus_rlen), 64'd0);

    // LW with addr_ok delayed 3 cycles, flush in WAIT, response drained
    @(negedge clk);
    set_op(1'b0, 3'b010, 64'h4004, 64'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("dly.req", 64'(dbus_req), 64'd1);
      check("dly.stall", 64'(mm_stall), 64'd1);
      check("dly.rlen", 64'(dbus_rlen), 64'd4);
      @(negedge clk);
    end
    dbus_addr_ok = 1'b1;
    @(negedge clk);
    dbus_addr_ok = 1'b0;
    flush        = 1'b1;
    #1;
    check("dly.wait_req", 64'(dbus_req), 64'd0);
    @(negedge clk);
    flush    = 1'b0;
    mm_valid = 1'b0;
    #1;
    check("drain.stall0", 64'(mm_stall), 64'd1);
    @(negedge clk);
    dbus_data_ok = 1'b1;
    dbus_rdata   = 64'hDEAD_BEEF_CAFE_F00D;
    #1;
    check("drain.stall1", 64'(mm_stall), 64'd1);
    check("drain.res", mm_put[0].res, 64'hFFFF_FFFF_FFFF_FF80);
    @(negedge clk);
    dbus_data_ok = 1'b0;
    dbus_rdata   = 64'h0;
    #1;
    check("drain.idle_stall", 64'(mm_stall), 64'd0);
    check("drain.res_keep", mm_put[0].res, 64'hFFFF_FFFF_FFFF_FF80);

    // SH at offset 6
    set_op(1'b1, 3'b001, 64'h2006, 64'h0000_0000_0000_BEEF);
    dbus_addr_ok = 1'b1;
    #1;
    check("sh.req", 64'(dbus_req), 64'd1);
    check("sh.we", 64'(dbus_we), 64'd1);
    check("sh.wstrb", 64'(dbus_wstrb), 64'hC0);
    check("sh.wdata", dbus_wdata, 64'hBEEF_BEEF_BEEF_BEEF);
    check("sh.rlen", 64'(dbus_rlen), 64'd2);
    check("sh.exc", 64'(mm_exc), 64'd0);
    @(negedge clk);
    dbus_addr_ok = 1'b0;
    dbus_data_ok = 1'b1;
    #1;
    check("sh.stall_wait", 64'(mm_stall), 64'd1);
    @(negedge clk);
    dbus_data_ok = 1'b0;
    #1;
    check("sh.stall_done", 64'(mm_stall), 64'd0);
    mm_valid = 1'b0;
    @(negedge clk);

    // SB and SW lane strobes
    set_op(1'b1, 3'b000, 64'h2005, 64'h0000_0000_0000_00A5);
    #1;
    check("sb.wstrb", 64'(dbus_wstrb), 64'h20);
    check("sb.wdata", dbus_wdata, 64'hA5A5_A5A5_A5A5_A5A5);
    set_op(1'b1, 3'b010, 64'h2004, 64'h0000_0000_1234_5678);
    #1;
    check("sw.wstrb", 64'(dbus_wstrb), 64'hF0);
    check("sw.wdata", dbus_wdata, 64'h1234_5678_1234_5678);

    // Misaligned LW and SD: exception, no request, no stall
    set_op(1'b0, 3'b010, 64'h3002, 64'h0);
    #1;
    check("lwmis.exc", 64'(mm_exc), 64'b001);
    check("lwmis.req", 64'(dbus_req), 64'd0);
    check("lwmis.stall", 64'(mm_stall), 64'd0);
    set_op(1'b1, 3'b011, 64'h3004, 64'h0);
    #1;
    check("sdmis.exc", 64'(mm_exc), 64'b010);
    check("sdmis.wstrb", 64'(dbus_wstrb), 64'd0);
    mm_valid = 1'b0;
    #1;
    check("novalid.exc", 64'(mm_exc), 64'd0);

    // Flush in IDLE withdraws the request in the same cycle
    set_op(1'b0, 3'b011, 64'h5000, 64'h0);
    flush = 1'b1;
    #1;
    check("iflush.req", 64'(dbus_req), 64'd0);
    check("iflush.stall", 64'(mm_stall), 64'd0);
    flush = 1'b0;
    @(negedge clk);

    // LD completing under wb_stall for 4 cycles
    dbus_addr_ok = 1'b1;
    #1;
    check("ld.req", 64'(dbus_req), 64'd1);
    @(negedge clk);
    dbus_addr_ok = 1'b0;
    dbus_data_ok = 1'b1;
    dbus_rdata   = 64'h0123_4567_89AB_CDEF;
    wb_stall     = 1'b1;
    @(negedge clk);
    dbus_data_ok = 1'b0;
    dbus_rdata   = 64'h0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("ldws.res", mm_put[0].res, 64'h0123_4567_89AB_CDEF);
      check("ldws.req", 64'(dbus_req), 64'd0);
      check("ldws.stall", 64'(mm_stall), 64'd0);
      @(negedge clk);
    end
    wb_stall = 1'b0;
    #1;
    check("ldws.req_release", 64'(dbus_req), 64'd0);
    mm_valid = 1'b0;
    @(negedge clk);
    #1;
    check("ldws.idle_res", mm_put[0].res, 64'h0123_4567_89AB_CDEF);

    // Zero-extend and sign-extend from upper lanes
    do_load("lhu", 3'b101, 64'h6006, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001);
    do_load("lw", 3'b010, 64'h7004, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
    check("lw.res1", mm_put[1].res, 64'h2222);

    // 32-bit datapath: LD/LWU/SD illegal, LW legal
    v32          = 1'b1;
    mp32.ena     = 1'b1;
    mp32.write   = 1'b0;
    mp32.funct3  = 3'b011;
    mp32.addr    = 64'h100;
    #1;
    check("x32ld.exc", 64'(exc32), 64'b100);
    check("x32ld.req", 64'(req32), 64'd0);
    check("x32ld.stall", 64'(stall32), 64'd0);
    mp32.funct3 = 3'b110;
    #1;
    check("x32lwu.exc", 64'(exc32), 64'b100);
    mp32.write  = 1'b1;
    mp32.funct3 = 3'b011;
    #1;
    check("x32sd.exc", 64'(exc32), 64'b100);
    mp32.funct3 = 3'b001;
    mp32.addr   = 64'h102;
    mp32.wdata  = 64'h0000_0000_0000_BEEF;
    #1;
    check("x32sh.req", 64'(req32), 64'd1);
    check("x32sh.wstrb", 64'(wstrb32), 64'hC);
    check("x32sh.wdata", 64'(wdata32), 64'hBEEF_BEEF);
    mp32.write  = 1'b0;
    mp32.funct3 = 3'b010;
    mp32.addr   = 64'h104;
    #1;
    check("x32lw.req", 64'(req32), 64'd1);
    check("x32lw.stall", 64'(stall32), 64'd1);
    v32 = 1'b0;
    #1;
    check("x32off.req", 64'(req32), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mm_lsu.md
# mm_lsu

Parametrised memory-stage load/store unit for the RV64 pipeline, successor to the combinational memory stage. It drives a split address/data handshake data bus, sizes each access at `XLEN` width, lane-aligns and sign/zero-extends read data, and flags misaligned or width-illegal accesses. It holds the pipeline with `mm_stall` while an access is outstanding, and drains responses belonging to flushed instructions.

## Interface
- `XLEN`, 64: datapath width, 32 or 64; `OFF = $clog2(XLEN/8)`.
- `ISSUE_NUM`, `` `ISSUE_NUM ``: number of issue slots passed through.
- `clk  in  1`: clock.
- `rst_n  in  1`: asynchronous, active-low reset.
- `mm_valid  in  1`: stage holds a live instruction.
- `mm_mempack  in  mempack_t`: fields `ena`, `write`, `funct3`, `addr`, `wdata`.
- `mm_get  in  regpack_t[ISSUE_NUM]`: writeback packets from the previous stage.
- `mm_decode_sign  in  decode_sign_t[ISSUE_NUM]`: per-slot `mm_read` selects load data.
- `flush  in  1`: kill the instruction in this stage.
- `wb_stall  in  1`: downstream cannot accept.
- `mm_put  out  regpack_t[ISSUE_NUM]`: writeback packets to the next stage.
- `mm_stall  out  1`: hold this stage and all upstream stages.
- `mm_exc  out  3`: {illegal_width, store_misalign, load_misalign}.
- `dbus_req  out  1`: access request.
- `dbus_we  out  1`: write access.
- `dbus_addr  out  XLEN`: access address.
- `dbus_wstrb  out  XLEN/8`: write byte enables.
- `dbus_wdata  out  XLEN`: write data.
- `dbus_rlen  out  4`: access size in bytes.
- `dbus_addr_ok  in  1`: request accepted this cycle.
- `dbus_data_ok  in  1`: read data valid or write complete.
- `dbus_rdata  in  XLEN`: read data, full bus word.

## Operation
- `access = mm_valid & mm_mempack.ena & ~flush`.
- Size from `funct3`: B=1, H=2, W=4, D=8 bytes.
- Misalignment: `addr[OFF-1:0]` not a multiple of the size.
- Illegal width (`XLEN=32` only): LD, LWU, SD.
- Any exception sets the matching `mm_exc` bit (combinational, while `mm_valid`), issues no request and does not stall.
- Write path:
  - `dbus_wstrb = ((1<<size)-1) << addr[OFF-1:0]`.
  - `dbus_wdata` = store data replicated across all lanes.
- Read path:
  - `dbus_rdata >> (8*addr[OFF-1:0])`.
  - Truncated to size, then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU) to `XLEN`.
- `mm_put[i]`: `rd`/`rd_en` pass through; `res = mm_read ? load_result : mm_get[i].res`.
- FSM states: IDLE, WAIT, DONE, DRAIN.
- IDLE:
  - `dbus_req = access & ~exc`, request fields driven from `mm_mempack`.
  - On `addr_ok`: latch size/sign/offset, go to WAIT.
- WAIT:
  - On `data_ok`: register the extended load result into `rdata_q`, go to DONE.
  - On `flush` without `data_ok`: go to DRAIN.
  - On `flush` with `data_ok`: go to IDLE.
- DONE:
  - `load_result = rdata_q`.
  - Stay while `wb_stall`.
  - Go to IDLE when `~wb_stall | flush`.
- DRAIN: discard the response; go to IDLE on `data_ok`.
- `mm_stall = (IDLE & dbus_req) | WAIT | DRAIN`.
- No request is issued outside IDLE, so at most one access is outstanding.

## Timing
- Reset: state IDLE, `rdata_q=0`. All outputs 0 while `mm_valid=0`: `dbus_req`, `dbus_we`, `dbus_wstrb`, `mm_stall`, `mm_exc`.
- Request outputs are combinational from `mm_mempack` in IDLE.
- `dbus_req` holds its fields stable until `addr_ok`.
- `data_ok` arrives no earlier than the cycle after `addr_ok`.
- Minimum load latency: request cycle, ≥1 WAIT cycle, result visible in the DONE cycle. `mm_stall` deasserts in DONE.
- `flush` in IDLE before `addr_ok` withdraws `dbus_req` in the same cycle.
- Reset mid-access returns to IDLE immediately. The bus is reset in the same domain, so no drain is needed.

## Structure
- In `def_cpu.svh`:
  - `lsu_state_e`.
  - `MM_EXC_*` bit indices.
  - A `funct3`-to-size/signed decode function.
- One sub-module, `mm_lsu_align`: combinational lane shift plus extension, parametrised by `XLEN`.

## Test plan
- LB at `addr=0x...3`, `rdata=0x00000000_80000000` (XLEN=64) -> `res=0xFFFF_FFFF_FFFF_FF80`; `mm_stall` high until DONE.
- SH at `addr=0x...6`, `wdata=0xBEEF` -> `wstrb=0xC0`, `dbus_wdata=0xBEEF` in all 4 halves.
- LW at `addr=0x...2` -> `mm_exc=3'b001`, `dbus_req=0`, `mm_stall=0`.
- `XLEN=32`, LD -> `mm_exc=3'b100`, no request.
- `addr_ok` delayed 3 cycles, then `flush` during WAIT -> DRAIN. `data_ok` 2 cycles later is discarded; IDLE follows, `mm_put.res` unchanged.
- LD completes while `wb_stall=1` for 4 cycles -> stays in DONE, `res` stable, no second `dbus_req`.
